player_weapon_ctrl: RTL
=======================

Name: player_weapon_ctrl

Overview:
Player-side aim and fire controller that feeds every enemy instance. It turns the rotate-left, rotate-right and fire buttons plus the weapon-select switches into a registered aim angle (hit_angle), a registered weapon type (shot_type) and a one-cycle fire pulse (outgoing_projectiles). It enforces a per-weapon cooldown and limits the ultimate weapon (type 11) with charges, which are refilled from the enemy kill counter.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new button level
COOLDOWN_1, 12500000, cooldown cycles after a type-01 (spread) shot
COOLDOWN_2, 25000000, cooldown cycles after a type-10 (medium) shot
COOLDOWN_3, 50000000, cooldown cycles after a type-11 (ultimate) shot
ULT_CHARGES, 2, ultimate charges at reset and the saturation ceiling (1..3)
KILLS_PER_CHARGE, 5, kills needed to earn one ultimate charge

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_left  in  1  raw rotate-counter-clockwise button, active-high, already synchronised
btn_right  in  1  raw rotate-clockwise button, active-high
btn_fire  in  1  raw fire button, active-high
shootingtype_sw  in  2  weapon select; 00 = safe
kill_count  in  16  enemy kill counter
game_over  in  1  freezes aiming and firing
hit_angle  out  4  current aim sector, 0..15
shot_type  out  2  weapon type of the latest accepted shot
outgoing_projectiles  out  1  one-cycle fire pulse
ready  out  1  high only in IDLE
ult_charges  out  2  ultimate charges remaining

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset values: hit_angle=0, shot_type=00, outgoing_projectiles=0, ready=1, ult_charges=ULT_CHARGES. FSM goes to IDLE; cooldown counter, kill accumulator and debouncers clear; the kill_count snapshot loads the current kill_count.
- Reset asserted during FIRE or COOLDOWN aborts the operation immediately.
- Debounce: each button's stable level changes only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. A 0->1 change of the stable level produces a one-cycle event (left_evt, right_evt, fire_evt).
- Aim:
  - right_evt increments hit_angle modulo 16 (15 -> 0).
  - left_evt decrements it modulo 16 (0 -> 15).
  - left_evt and right_evt in the same cycle: no change.
  - The update is registered and appears the cycle after the event.
  - Aim events are ignored while game_over=1 and during the FIRE cycle, so hit_angle is stable for the whole pulse.
- FSM with three states: IDLE, FIRE, COOLDOWN.
  - IDLE -> FIRE when fire_evt=1, game_over=0, shootingtype_sw!=00, and (shootingtype_sw!=11 or ult_charges>0). On that transition shot_type <= shootingtype_sw. A fire_evt that fails these conditions is discarded.
  - FIRE lasts exactly 1 cycle, with outgoing_projectiles=1 and ready=0. If shot_type=11, ult_charges decrements in this cycle. The cooldown counter loads COOLDOWN_n for the current shot_type.
  - COOLDOWN lasts exactly COOLDOWN_n cycles, then returns to IDLE.
  - fire_evt outside IDLE is dropped, not queued.
  - Latency: fire_evt at cycle t gives outgoing_projectiles at t+1 and ready at t+2 + COOLDOWN_n.
  - game_over rising during COOLDOWN does not cut the cooldown short.
- Kill recharge:
  - Snapshot is the kill_count value of the previous cycle.
  - kill_count == snapshot+1 (modulo 2^16) counts as one kill.
  - Any other change only resynchronises the snapshot and counts nothing (enemy reset to 0).
  - The accumulator counts 0..KILLS_PER_CHARGE-1. On wrap, ult_charges increments, saturating at ULT_CHARGES; the wrap still occurs when saturated.
  - Kill recharge and the FIRE-cycle ultimate decrement in the same cycle leave ult_charges unchanged.
- Cooldown counter is 26 bits; all counters compare with == against parameter values.

Decomposition:
- Shared package holds:
  - weapon-type constants W_SAFE=00, W_SPREAD=01, W_MEDIUM=10, W_ULT=11;
  - FSM state encoding;
  - the 4-bit angle type.
- One sub-module: button_debounce (raw in, stable-level out, rise-event out, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, COOLDOWN_1/2/3=10/20/40, ULT_CHARGES=2, KILLS_PER_CHARGE=3.
1. Reset, hold btn_right high 5 cycles -> hit_angle goes 0->1 exactly once. Sixteen debounced right presses -> hit_angle back to 0. One left press from 0 -> 15.
2. btn_right toggled every 2 cycles for 20 cycles (bounce) -> hit_angle unchanged.
3. shootingtype_sw=01, debounced fire -> outgoing_projectiles high 1 cycle with shot_type=01. ready low for 11 cycles. A second fire at cooldown cycle 5 produces no pulse.
4. shootingtype_sw=11, three spaced fires -> pulses on shots 1 and 2 only, ult_charges 2->1->0. Third shot: no pulse.
5. With ult_charges=0, kill_count 0->1->2->3 one step per cycle -> ult_charges=1. Then kill_count jumps to 0 -> no change.
6. Fire with shootingtype_sw=00, or with game_over=1 -> no pulse, ready stays 1. Reset asserted mid-COOLDOWN -> next cycle ready=1 and hit_angle=0.

Source files
------------

// File: rtl/player_weapon_ctrl_pkg.sv
// Shared types and constants for the player aim/fire controller.
package player_weapon_ctrl_pkg;

  localparam logic [1:0] W_SAFE   = 2'b00;
  localparam logic [1:0] W_SPREAD = 2'b01;
  localparam logic [1:0] W_MEDIUM = 2'b10;
  localparam logic [1:0] W_ULT    = 2'b11;

  localparam int unsigned CooldownW = 26;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StCooldown
  } fsm_state_e;

  typedef logic [3:0] angle_t;

endpackage

// File: rtl/button_debounce.sv
// Accepts a new button level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // Any sample matching the stable level restarts the count.
    if (raw != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = raw;
        rise_d  = raw;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/player_weapon_ctrl.sv
// Player aim/fire controller: debounced buttons drive the aim sector and a
// cooldown-limited fire pulse; ultimate shots consume charges refilled by kills.
module player_weapon_ctrl
  import player_weapon_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 250000,
  parameter int unsigned COOLDOWN_1       = 12500000,
  parameter int unsigned COOLDOWN_2       = 25000000,
  parameter int unsigned COOLDOWN_3       = 50000000,
  parameter int unsigned ULT_CHARGES      = 2,
  parameter int unsigned KILLS_PER_CHARGE = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic [1:0]  shootingtype_sw,
  input  logic [15:0] kill_count,
  input  logic        game_over,
  output logic [3:0]  hit_angle,
  output logic [1:0]  shot_type,
  output logic        outgoing_projectiles,
  output logic        ready,
  output logic [1:0]  ult_charges
);

  localparam int unsigned AccW = $clog2(KILLS_PER_CHARGE + 1);

  logic [2:0] unused_btn_level;
  logic       left_evt, right_evt, fire_evt;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_left),
    .level (unused_btn_level[0]),
    .rise  (left_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_right),
    .level (unused_btn_level[1]),
    .rise  (right_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_fire),
    .level (unused_btn_level[2]),
    .rise  (fire_evt)
  );

  fsm_state_e           state_q, state_d;
  angle_t               angle_q, angle_d;
  logic [1:0]           shot_q, shot_d;
  logic [CooldownW-1:0] cd_q, cd_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [1:0]           chg_q, chg_d;
  logic [15:0]          snap_q;

  logic fire_ok, ult_dec, kill_evt, wrap;
  logic [CooldownW-1:0] cd_len;

  always_comb begin
    unique case (shot_q)
      W_MEDIUM: cd_len = CooldownW'(COOLDOWN_2);
      W_ULT:    cd_len = CooldownW'(COOLDOWN_3);
      default:  cd_len = CooldownW'(COOLDOWN_1);
    endcase
  end

  assign fire_ok = fire_evt && !game_over && (shootingtype_sw != W_SAFE) &&
                   ((shootingtype_sw != W_ULT) || (chg_q != 2'd0));

  always_comb begin
    state_d = state_q;
    shot_d  = shot_q;
    cd_d    = cd_q;
    unique case (state_q)
      StIdle: begin
        if (fire_ok) begin
          state_d = StFire;
          shot_d  = shootingtype_sw;
        end
      end
      StFire: begin
        state_d = StCooldown;
        cd_d    = cd_len;
      end
      StCooldown: begin
        if (cd_q == CooldownW'(1)) begin
          state_d = StIdle;
          cd_d    = '0;
        end else begin
          cd_d = cd_q - CooldownW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Aim is frozen during the fire pulse so the shot carries a stable angle.
  always_comb begin
    angle_d = angle_q;
    if (!game_over && (state_q != StFire)) begin
      if (right_evt && !left_evt) begin
        angle_d = angle_q + angle_t'(1);
      end else if (left_evt && !right_evt) begin
        angle_d = angle_q - angle_t'(1);
      end
    end
  end

  // Only a +1 step of kill_count is a kill; other jumps just resynchronise.
  assign kill_evt = (kill_count == snap_q + 16'd1);
  assign ult_dec  = (state_q == StFire) && (shot_q == W_ULT);

  always_comb begin
    acc_d = acc_q;
    wrap  = 1'b0;
    if (kill_evt) begin
      if (acc_q == AccW'(KILLS_PER_CHARGE - 1)) begin
        acc_d = '0;
        wrap  = 1'b1;
      end else begin
        acc_d = acc_q + AccW'(1);
      end
    end
  end

  always_comb begin
    chg_d = chg_q;
    if (wrap && !ult_dec) begin
      if (chg_q != 2'(ULT_CHARGES)) begin
        chg_d = chg_q + 2'd1;
      end
    end else if (ult_dec && !wrap) begin
      chg_d = chg_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      angle_q <= '0;
      shot_q  <= W_SAFE;
      cd_q    <= '0;
      acc_q   <= '0;
      chg_q   <= 2'(ULT_CHARGES);
      snap_q  <= kill_count;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      shot_q  <= shot_d;
      cd_q    <= cd_d;
      acc_q   <= acc_d;
      chg_q   <= chg_d;
      snap_q  <= kill_count;
    end
  end

  assign hit_angle            = angle_q;
  assign shot_type            = shot_q;
  assign outgoing_projectiles = (state_q == StFire);
  assign ready                = (state_q == StIdle);
  assign ult_charges          = chg_q;

endmodule
